// File: rtl/idle_wakeup_ctrl.sv
// Purpose: after a committed IDLE, halt the frontend until a pending interrupt persists, then redirect to idle_pc+4.
// Latency: WAKE_HOLD cycles of continuous pending in HALT before the redirect is raised; wake_o fires on the handshake cycle.
// Backpressure: redirect_valid_o/redirect_pc_o hold stable until redirect_ready_i; an exception flush in WAKE abandons the redirect.
module idle_wakeup_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int INT_W     = 13,
    parameter int CNT_W     = 32,
    parameter int WAKE_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle_flush_i,
    input  logic [ADDR_W-1:0] idle_pc_i,
    input  logic              excp_flush_i,
    input  logic              ertn_flush_i,
    input  logic [INT_W-1:0]  int_pending_i,
    input  logic              redirect_ready_i,
    output logic              halt_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              wake_o,
    output logic              idle_busy_o,
    output logic [CNT_W-1:0]  idle_cycles_o
);

    localparam int HOLD_W = (WAKE_HOLD > 1) ? $clog2(WAKE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WAKE_HOLD - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        WAKE = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W-1:0] target_pc;
    logic [CNT_W-1:0]  idle_cnt;
    logic              int_pend;

    assign int_pend = |int_pending_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            hold_cnt  <= '0;
            target_pc <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    hold_cnt <= '0;
                    // A same-cycle exception or ertn flush takes priority over the IDLE.
                    if (idle_flush_i && !excp_flush_i && !ertn_flush_i) begin
                        target_pc <= idle_pc_i + ADDR_W'(4);
                        state     <= HALT;
                    end
                end
                HALT: begin
                    if (idle_cnt != '1)
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    if (!int_pend) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= WAKE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                WAKE: begin
                    if (excp_flush_i || redirect_ready_i)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign halt_o           = (state != RUN);
    assign idle_busy_o      = (state != RUN);
    assign redirect_valid_o = (state == WAKE);
    assign redirect_pc_o    = target_pc;
    assign wake_o           = (state == WAKE) && redirect_ready_i && !excp_flush_i;
    assign idle_cycles_o    = idle_cnt;

endmodule

// File: tb/tb_idle_wakeup_ctrl.sv
// Bench for idle_wakeup_ctrl: vector table on a WAKE_HOLD=1 instance, hand sequences on it and a WAKE_HOLD=3/CNT_W=4 instance.
module tb_idle_wakeup_ctrl;

    typedef struct packed {
        logic        idle;
        logic [31:0] pc;
        logic        excp;
        logic        ertn;
        logic [12:0] intp;
        logic        rdy;
        logic        e_halt;
        logic        e_vld;
        logic        e_wake;
        logic        e_busy;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        idle_flush = 1'b0;
    logic [31:0] idle_pc = '0;
    logic        excp_flush = 1'b0;
    logic        ertn_flush = 1'b0;
    logic [12:0] int_pending = '0;
    logic        redirect_ready = 1'b0;

    logic        a_halt, a_vld, a_wake, a_busy;
    logic [31:0] a_pc, a_cnt;
    logic        b_halt, b_vld, b_wake, b_busy;
    logic [31:0] b_pc;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fail = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    idle_wakeup_ctrl #(.ADDR_W(32), .INT_W(13), .CNT_W(32), .WAKE_HOLD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .idle_flush_i(idle_flush), .idle_pc_i(idle_pc),
        .excp_flush_i(excp_flush), .ertn_flush_i(ertn_flush), .int_pending_i(int_pending),
        .redirect_ready_i(redirect_ready), .halt_o(a_halt), .redirect_valid_o(a_vld),
        .redirect_pc_o(a_pc), .wake_o(a_wake), .idle_busy_o(a_busy), .idle_cycles_o(a_cnt)
    );

    idle_wakeup_ctrl #(.ADDR_W(32), .INT_W(13), .CNT_W(4), .WAKE_HOLD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .idle_flush_i(idle_flush), .idle_pc_i(idle_pc),
        .excp_flush_i(excp_flush), .ertn_flush_i(ertn_flush), .int_pending_i(int_pending),
        .redirect_ready_i(redirect_ready), .halt_o(b_halt), .redirect_valid_o(b_vld),
        .redirect_pc_o(b_pc), .wake_o(b_wake), .idle_busy_o(b_busy), .idle_cycles_o(b_cnt)
    );

    function automatic vec_t mk(input logic idle, input logic [31:0] pc, input logic ex,
                                input logic er, input logic [12:0] ip, input logic rdy,
                                input logic h, input logic v, input logic w, input logic b,
                                input logic [31:0] epc, input logic [31:0] ecnt);
        vec_t r;
        r.idle = idle; r.pc = pc; r.excp = ex; r.ertn = er; r.intp = ip; r.rdy = rdy;
        r.e_halt = h; r.e_vld = v; r.e_wake = w; r.e_busy = b; r.e_pc = epc; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are observed on the falling edge.
    task automatic set_in(input logic idle, input logic [31:0] pc, input logic ex,
                          input logic er, input logic [12:0] ip, input logic rdy);
        @(posedge clk);
        #1;
        idle_flush = idle; idle_pc = pc; excp_flush = ex; ertn_flush = er;
        int_pending = ip; redirect_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        idle_flush = 1'b0; idle_pc = '0; excp_flush = 1'b0; ertn_flush = 1'b0;
        int_pending = '0; redirect_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(0, 32'h0,   0, 0, 13'h0,    0, 0, 0, 0, 0, 32'h0,   0);
        vecs[1]  = mk(1, 32'h100, 1, 0, 13'h0,    0, 0, 0, 0, 0, 32'h0,   0);
        vecs[2]  = mk(1, 32'h200, 0, 1, 13'h0,    0, 0, 0, 0, 0, 32'h0,   0);
        vecs[3]  = mk(1, 32'h300, 0, 0, 13'h0,    0, 0, 0, 0, 0, 32'h0,   0);
        vecs[4]  = mk(0, 32'h0,   0, 0, 13'h0,    0, 1, 0, 0, 1, 32'h304, 0);
        vecs[5]  = mk(1, 32'h999, 1, 1, 13'h0,    0, 1, 0, 0, 1, 32'h304, 1);
        vecs[6]  = mk(0, 32'h0,   0, 0, 13'h001,  0, 1, 0, 0, 1, 32'h304, 2);
        vecs[7]  = mk(0, 32'h0,   0, 0, 13'h0,    0, 1, 1, 0, 1, 32'h304, 3);
        vecs[8]  = mk(0, 32'h0,   0, 0, 13'h0,    1, 1, 1, 1, 1, 32'h304, 3);
        vecs[9]  = mk(0, 32'h0,   0, 0, 13'h0,    0, 0, 0, 0, 0, 32'h304, 3);
        vecs[10] = mk(1, 32'h400, 0, 0, 13'h0,    0, 0, 0, 0, 0, 32'h304, 3);
        vecs[11] = mk(0, 32'h0,   0, 0, 13'h1000, 0, 1, 0, 0, 1, 32'h404, 3);
        vecs[12] = mk(0, 32'h0,   1, 0, 13'h0,    1, 1, 1, 0, 1, 32'h404, 4);
        vecs[13] = mk(0, 32'h0,   0, 0, 13'h0,    0, 0, 0, 0, 0, 32'h404, 4);

        // Reset state of both instances.
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_a", 80'({a_halt, a_vld, a_wake, a_busy, a_pc, a_cnt}), 80'(0));
        chk("reset_b", 80'({b_halt, b_vld, b_wake, b_busy, b_pc, b_cnt}), 80'(0));
        do_reset();

        // Table: flush priority, HALT ignoring flushes, wake without revoke, excp abort in WAKE.
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].idle, vecs[i].pc, vecs[i].excp, vecs[i].ertn, vecs[i].intp, vecs[i].rdy);
            chk($sformatf("vec%0d", i), 80'({a_halt, a_vld, a_wake, a_busy, a_pc, a_cnt}),
                80'({vecs[i].e_halt, vecs[i].e_vld, vecs[i].e_wake, vecs[i].e_busy,
                     vecs[i].e_pc, vecs[i].e_cnt}));
        end

        // IDLE at 0x1C000100, 50 quiet cycles, then int[11], held ready low for 5 cycles.
        do_reset();
        set_in(1, 32'h1C000100, 0, 0, 13'h0, 0);
        for (int i = 0; i < 50; i++) set_in(0, 32'h0, 0, 0, 13'h0, 0);
        set_in(0, 32'h0, 0, 0, 13'h800, 0);
        chk("s1_halt_cnt50", 80'({a_halt, a_vld, a_cnt}), 80'({1'b1, 1'b0, 32'd50}));
        set_in(0, 32'h0, 0, 0, 13'h800, 0);
        chk("s1_wake_pc", 80'({a_halt, a_vld, a_wake, a_pc}), 80'({3'b110, 32'h1C000104}));
        for (int i = 0; i < 5; i++) begin
            set_in(0, 32'h0, 0, 0, 13'h0, 0);
            chk($sformatf("s2_stall%0d", i), 80'({a_halt, a_vld, a_wake, a_pc}),
                80'({3'b110, 32'h1C000104}));
        end
        set_in(0, 32'h0, 0, 0, 13'h0, 1);
        chk("s2_handshake", 80'({a_halt, a_vld, a_wake, a_pc}), 80'({3'b111, 32'h1C000104}));
        set_in(0, 32'h0, 0, 0, 13'h0, 1);
        chk("s2_back_run", 80'({a_halt, a_vld, a_wake, a_busy}), 80'(4'b0000));

        // WAKE_HOLD=3 glitch rejection, PC wrap and 4-bit counter saturation.
        do_reset();
        set_in(1, 32'hFFFFFFFC, 0, 0, 13'h0, 0);
        for (int i = 0; i < 15; i++) set_in(0, 32'h0, 0, 0, 13'h0, 0);
        chk("s5_cnt_pre_sat", 80'(b_cnt), 80'(4'hE));
        for (int i = 0; i < 2; i++) begin
            set_in(0, 32'h0, 0, 0, 13'h004, 0);
            chk($sformatf("s3_glitch%0d", i), 80'({b_halt, b_vld}), 80'(2'b10));
        end
        set_in(0, 32'h0, 0, 0, 13'h0, 0);
        chk("s3_drop", 80'({b_halt, b_vld}), 80'(2'b10));
        for (int i = 0; i < 3; i++) begin
            set_in(0, 32'h0, 0, 0, 13'h004, 0);
            chk($sformatf("s3_hold%0d", i), 80'({b_halt, b_vld}), 80'(2'b10));
        end
        set_in(0, 32'h0, 0, 0, 13'h004, 0);
        chk("s3_wake_after3", 80'({b_halt, b_vld, b_wake}), 80'(3'b110));
        chk("s5_pc_wrap", 80'(b_pc), 80'(32'h0));
        chk("s5_cnt_sat", 80'(b_cnt), 80'(4'hF));
        set_in(0, 32'h0, 0, 0, 13'h0, 1);
        chk("s3_wake_pulse", 80'({b_vld, b_wake, b_cnt}), 80'({2'b11, 4'hF}));

        // Asynchronous reset between edges while the redirect is being accepted.
        do_reset();
        set_in(1, 32'h00001000, 0, 0, 13'h0, 0);
        set_in(0, 32'h0, 0, 0, 13'h001, 0);
        set_in(0, 32'h0, 0, 0, 13'h0, 1);
        chk("s6_pre_reset", 80'({a_halt, a_vld, a_wake}), 80'(3'b111));
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_clear", 80'({a_halt, a_vld, a_wake, a_busy, a_pc}), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 32'h0, 0, 0, 13'h0, 1);
        chk("s6_run_after", 80'({a_halt, a_vld, a_wake, a_busy}), 80'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
